// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared event encodings, status nibbles and FSM states for the MIDI transmitter
package synth_pkg;

   typedef enum logic [2:0] {
      EV_NOTE_OFF = 3'd0,
      EV_NOTE_ON  = 3'd1,
      EV_CONTROL  = 3'd2,
      EV_PROGRAM  = 3'd3,
      EV_PITCH    = 3'd4
   } ev_type_e;

   localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
   localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
   localparam logic [3:0] NIB_CONTROL  = 4'hB;
   localparam logic [3:0] NIB_PROGRAM  = 4'hC;
   localparam logic [3:0] NIB_PITCH    = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STATUS,
      ST_DATA1,
      ST_DATA2
   } state_e;

   function automatic logic [3:0] status_nibble(input logic [2:0] t);
      case (t)
         EV_NOTE_ON: status_nibble = NIB_NOTE_ON;
         EV_CONTROL: status_nibble = NIB_CONTROL;
         EV_PROGRAM: status_nibble = NIB_PROGRAM;
         EV_PITCH:   status_nibble = NIB_PITCH;
         default:    status_nibble = NIB_NOTE_OFF;
      endcase
   endfunction

   function automatic logic is_reserved(input logic [2:0] t);
      return t > EV_PITCH;
   endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// rtl/midi_uart_tx.sv - 8N1 byte serializer; ready rises in the last stop-bit cycle so the
// next byte can follow with no idle gap.
module midi_uart_tx #(
   parameter int BAUD_DIV = 1600
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [7:0] byte_i,
   output logic       ready_o,
   output logic       txd_o
);

   localparam int BW = $clog2(BAUD_DIV + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   logic          active_q, active_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic [8:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic          bit_end, frame_end;

   assign bit_end   = (baud_q == BAUD_LAST);
   assign frame_end = active_q && bit_end && (bit_q == 4'd9);
   assign ready_o   = !active_q || frame_end;
   assign txd_o     = txd_q;

   always_comb begin
      active_d = active_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      txd_d    = txd_q;
      if (load_i && ready_o) begin
         // shift register holds data plus the stop bit; start bit goes straight to the line
         active_d = 1'b1;
         baud_d   = '0;
         bit_d    = 4'd0;
         shift_d  = {1'b1, byte_i};
         txd_d    = 1'b0;
      end else if (active_q) begin
         if (bit_end) begin
            baud_d = '0;
            if (bit_q == 4'd9) begin
               active_d = 1'b0;
               txd_d    = 1'b1;
            end else begin
               txd_d   = shift_q[0];
               shift_d = {1'b1, shift_q[8:1]};
               bit_d   = bit_q + 4'd1;
            end
         end else begin
            baud_d = baud_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= 4'd0;
         shift_q  <= '1;
         txd_q    <= 1'b1;
      end else begin
         active_q <= active_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
      end
   end

endmodule

// File: rtl/midi_event_tx.sv
// rtl/midi_event_tx.sv - MIDI event framer: latches one event, applies running status and
// feeds status/data bytes to the serializer back-to-back.
module midi_event_tx
   import synth_pkg::*;
#(
   parameter int BAUD_DIV       = 1600,
   parameter int RUNNING_STATUS = 1
) (
   input  logic       reg_clk,
   input  logic       reset_reg,
   input  logic [3:0] midi_ch,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [2:0] ev_type,
   input  logic [6:0] ev_data1,
   input  logic [6:0] ev_data2,
   output logic       midi_txd,
   output logic       busy
);

   state_e     state_q, state_d, next_st, load_sel;
   logic [3:0] ch_q, ch_d;
   logic [2:0] type_q, type_d;
   logic [6:0] d1_q, d1_d, d2_q, d2_d;
   logic [7:0] last_q, last_d;
   logic       lead_q, lead_d;
   logic       sent_q, sent_d;
   logic       hold_q, hold_d;
   logic       accept, load, uart_ready;
   logic [7:0] tx_byte, status_in, status_cur;

   assign ev_ready   = (state_q == ST_IDLE) && !hold_q;
   assign busy       = ~ev_ready;
   assign accept     = ev_valid && ev_ready && !reset_reg;
   assign status_in  = {status_nibble(ev_type), midi_ch};
   assign status_cur = {status_nibble(type_q), ch_q};

   // lead_q spends one cycle after accept so the first start bit lands two cycles out;
   // sent_q marks that the current state's byte is already in the serializer.
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      type_d   = type_q;
      d1_d     = d1_q;
      d2_d     = d2_q;
      last_d   = last_q;
      sent_d   = sent_q;
      lead_d   = 1'b0;
      hold_d   = 1'b0;
      load     = 1'b0;
      load_sel = state_q;
      case (state_q)
         ST_STATUS: next_st = ST_DATA1;
         ST_DATA1:  next_st = (type_q == EV_PROGRAM) ? ST_IDLE : ST_DATA2;
         default:   next_st = ST_IDLE;
      endcase
      if (state_q == ST_IDLE) begin
         if (accept) begin
            ch_d   = midi_ch;
            type_d = ev_type;
            d1_d   = ev_data1;
            d2_d   = ev_data2;
            sent_d = 1'b0;
            if (is_reserved(ev_type)) begin
               hold_d = 1'b1;
            end else begin
               lead_d = 1'b1;
               if ((RUNNING_STATUS != 0) && (status_in == last_q)) state_d = ST_DATA1;
               else state_d = ST_STATUS;
            end
         end
      end else if (!lead_q) begin
         if (!sent_q) begin
            load   = 1'b1;
            sent_d = 1'b1;
            if (state_q == ST_STATUS) last_d = status_cur;
         end else if (uart_ready) begin
            // hand over the next byte on the same edge the current frame ends
            state_d = next_st;
            if (next_st != ST_IDLE) begin
               load     = 1'b1;
               load_sel = next_st;
            end else begin
               sent_d = 1'b0;
            end
         end
      end
      case (load_sel)
         ST_STATUS: tx_byte = status_cur;
         ST_DATA2:  tx_byte = {1'b0, d2_q};
         default:   tx_byte = {1'b0, d1_q};
      endcase
   end

   always_ff @(posedge reg_clk) begin
      if (reset_reg) begin
         state_q <= ST_IDLE;
         ch_q    <= 4'd0;
         type_q  <= 3'd0;
         d1_q    <= 7'd0;
         d2_q    <= 7'd0;
         last_q  <= 8'h00;
         lead_q  <= 1'b0;
         sent_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         type_q  <= type_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         last_q  <= last_d;
         lead_q  <= lead_d;
         sent_q  <= sent_d;
         hold_q  <= hold_d;
      end
   end

   midi_uart_tx #(
      .BAUD_DIV(BAUD_DIV)
   ) u_uart (
      .clk_i  (reg_clk),
      .rst_i  (reset_reg),
      .load_i (load),
      .byte_i (tx_byte),
      .ready_o(uart_ready),
      .txd_o  (midi_txd)
   );

endmodule

// File: tb/tb_midi_event_tx.sv
// tb/tb_midi_event_tx.sv - checks two transmitters (running status on/off) against a
// cycle-level waveform model built from the MIDI framing rules.
module tb_midi_event_tx;

   localparam int B       = 4;
   localparam int BYTE_CY = 10 * B;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ch;
   logic [2:0] typ;
   logic [6:0] d1, d2;
   logic [1:0] valid;
   logic [1:0] ready, txd, busy;

   always #5 clk = ~clk;

   midi_event_tx #(.BAUD_DIV(B), .RUNNING_STATUS(1)) dut_rs (
      .reg_clk(clk), .reset_reg(rst), .midi_ch(ch), .ev_valid(valid[0]), .ev_ready(ready[0]),
      .ev_type(typ), .ev_data1(d1), .ev_data2(d2), .midi_txd(txd[0]), .busy(busy[0]));

   midi_event_tx #(.BAUD_DIV(B), .RUNNING_STATUS(0)) dut_plain (
      .reg_clk(clk), .reset_reg(rst), .midi_ch(ch), .ev_valid(valid[1]), .ev_ready(ready[1]),
      .ev_type(typ), .ev_data1(d1), .ev_data2(d2), .midi_txd(txd[1]), .busy(busy[1]));

   int         checks = 0;
   int         errors = 0;
   bit         started = 1'b0;
   bit         m_txq   [2][$];
   logic [7:0] m_bytes [2][$];
   int         m_busy  [2] = '{0, 0};
   bit         m_txd   [2] = '{1'b1, 1'b1};
   bit         m_acc   [2] = '{1'b0, 1'b0};
   logic [7:0] m_last  [2] = '{8'h00, 8'h00};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] nib(input logic [2:0] t);
      case (t)
         3'd0: return 4'h8;
         3'd1: return 4'h9;
         3'd2: return 4'hB;
         3'd3: return 4'hC;
         default: return 4'hE;
      endcase
   endfunction

   // Expected line for one accepted event: two idle cycles, then 8N1 frames back-to-back.
   task automatic accept(input int i);
      logic [7:0] st;
      logic [7:0] by;
      m_acc[i] = 1'b1;
      m_bytes[i].delete();
      if (typ > 3'd4) begin
         m_busy[i] = 1;
         return;
      end
      st = {nib(typ), ch};
      if (!(i == 0 && st == m_last[i])) begin
         m_bytes[i].push_back(st);
         m_last[i] = st;
      end
      m_bytes[i].push_back({1'b0, d1});
      if (typ != 3'd3) m_bytes[i].push_back({1'b0, d2});
      m_busy[i] = 2 + BYTE_CY * m_bytes[i].size();
      m_txq[i].push_back(1'b1);
      m_txq[i].push_back(1'b1);
      for (int k = 0; k < m_bytes[i].size(); k++) begin
         by = m_bytes[i][k];
         repeat (B) m_txq[i].push_back(1'b0);
         for (int b = 0; b < 8; b++) repeat (B) m_txq[i].push_back(by[b]);
         repeat (B) m_txq[i].push_back(1'b1);
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m_acc[i] = 1'b0;
         if (rst) begin
            m_txq[i].delete();
            m_busy[i] = 0;
            m_txd[i]  = 1'b1;
            m_last[i] = 8'h00;
         end else begin
            if (m_busy[i] == 0 && valid[i]) accept(i);
            else if (m_busy[i] > 0) m_busy[i]--;
            m_txd[i] = (m_txq[i].size() > 0) ? m_txq[i].pop_front() : 1'b1;
         end
      end
      if (rst) started = 1'b1;
   end

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("txd%0d", i), txd[i], m_txd[i]);
            chk($sformatf("ready%0d", i), ready[i], m_busy[i] == 0);
            chk($sformatf("busy%0d", i), busy[i], m_busy[i] != 0);
         end
      end
   end

   task automatic send(input logic [3:0] c, input logic [2:0] t, input logic [6:0] a,
                       input logic [6:0] b);
      int cyc = 0;
      ch = c; typ = t; d1 = a; d2 = b; valid = 2'b11;
      while (valid != 2'b00 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) if (m_acc[i]) valid[i] = 1'b0;
      end
      chk("send_accepted", valid, 2'b00);
      valid = 2'b00;
      ch = 4'($urandom); typ = 3'($urandom); d1 = 7'($urandom); d2 = 7'($urandom);
   endtask

   // Counts busy cycles of the running-status unit from the accept cycle on, and the
   // cycle index of its first low line sample.
   task automatic wait_idle(output int n0, output int first_low);
      int cyc = 0;
      n0 = 0;
      first_low = -1;
      while (!(ready[0] && ready[1]) && cyc < 2000) begin
         if (busy[0]) n0++;
         if (!txd[0] && first_low < 0) first_low = cyc;
         @(negedge clk);
         cyc++;
      end
      chk("idle_timeout", cyc < 2000, 1'b1);
   endtask

   task automatic chk_bytes(input string nm, input int i, input int n, input logic [23:0] exp);
      logic [23:0] got = '0;
      for (int k = 0; k < m_bytes[i].size() && k < 3; k++) got = {got[15:0], m_bytes[i][k]};
      chk({nm, "_count"}, m_bytes[i].size(), n);
      chk(nm, got, exp);
   endtask

   initial begin
      int n, f;
      rst = 1'b1; valid = 2'b00; ch = 4'd0; typ = 3'd0; d1 = 7'd0; d2 = 7'd0;
      repeat (3) @(negedge clk);
      chk("reset_txd", txd[0], 1'b1);
      chk("reset_ready", ready[0], 1'b1);
      chk("reset_busy", busy[0], 1'b0);
      rst = 1'b0;

      send(4'd2, 3'd1, 7'h3C, 7'h64);
      wait_idle(n, f);
      chk_bytes("note_on_rs", 0, 3, 24'h923C64);
      chk_bytes("note_on_plain", 1, 3, 24'h923C64);
      chk("note_on_busy_len", n, 122);
      chk("note_on_start_delay", f, 2);

      send(4'd2, 3'd1, 7'h40, 7'h7F);
      wait_idle(n, f);
      chk_bytes("running_rs", 0, 2, 24'h00407F);
      chk_bytes("running_plain", 1, 3, 24'h92407F);
      chk("running_busy_len", n, 82);

      send(4'd0, 3'd3, 7'h05, 7'h11);
      wait_idle(n, f);
      chk_bytes("program", 0, 2, 24'h00C005);
      chk("program_busy_len", n, 82);

      send(4'd0, 3'd2, 7'h07, 7'h50);
      wait_idle(n, f);
      chk_bytes("control", 0, 3, 24'hB00750);

      send(4'd15, 3'd4, 7'h00, 7'h40);
      wait_idle(n, f);
      chk_bytes("pitch", 0, 3, 24'hEF0040);

      send(4'd3, 3'd6, 7'h12, 7'h34);
      wait_idle(n, f);
      chk_bytes("reserved", 0, 0, 24'h000000);
      chk("reserved_busy_len", n, 1);
      chk("reserved_no_start", f, -1);

      send(4'd2, 3'd1, 7'h3C, 7'h64);
      repeat (58) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_txd", txd[0], 1'b1);
      chk("abort_ready", ready[0], 1'b1);
      send(4'd2, 3'd1, 7'h3C, 7'h64);
      wait_idle(n, f);
      chk_bytes("after_abort", 0, 3, 24'h923C64);
      chk("after_abort_busy_len", n, 122);

      valid = 2'b11;
      for (int c = 0; c < 4000; c++) begin
         ch  = 4'($urandom_range(0, 1));
         typ = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         d1  = 7'($urandom);
         d2  = 7'($urandom);
         @(negedge clk);
      end
      valid = 2'b00;
      wait_idle(n, f);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/midi_event_tx.md
MIDI_EVENT_TX -- requirements
Module: midi_event_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 1600, giving reg_clk cycles per MIDI bit (50 MHz / 31250 baud).
REQ-002 SHALL have parameter RUNNING_STATUS, default 1, where 1 enables running-status compression.
REQ-003 SHALL have port reg_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_reg, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port midi_ch, input, 4 bits: transmit channel, sampled on event accept.
REQ-006 SHALL have port ev_valid, input, 1 bit: an event is offered.
REQ-007 SHALL have port ev_ready, output, 1 bit: the block can accept an event.
REQ-008 SHALL have port ev_type, input, 3 bits: 0 note off, 1 note on, 2 controller, 3 program change, 4 pitch bend, 5-7 reserved.
REQ-009 SHALL have port ev_data1, input, 7 bits: key, controller number, program, or pitch LSB.
REQ-010 SHALL have port ev_data2, input, 7 bits: velocity, controller value, or pitch MSB.
REQ-011 SHALL have port midi_txd, output, 1 bit: serial MIDI out, idle high.
REQ-012 SHALL have port busy, output, 1 bit: high while any byte of an event is pending or shifting.

Function
REQ-013 SHALL accept an event on a cycle where ev_valid and ev_ready are both high; ev_ready is high only in state IDLE.
REQ-014 SHALL latch midi_ch, ev_type, ev_data1 and ev_data2 on accept; input changes afterwards have no effect on that event.
REQ-015 SHALL form the status byte as {upper nibble, midi_ch}, with upper nibble 8/9/B/C/E for types 0-4.
REQ-016 SHALL send 3 bytes (status, data1, data2) for types 0, 1, 2 and 4, and 2 bytes (status, data1) for type 3.
REQ-017 SHALL accept reserved types 5-7, transmit nothing, and keep ev_ready low for exactly one cycle after the accept.
REQ-018 SHALL, when RUNNING_STATUS=1, omit the status byte if it equals last_status; last_status updates whenever a status byte is sent.
REQ-019 SHALL force bit 7 of every data byte to 0.
REQ-020 SHALL run the FSM IDLE -> STATUS -> DATA1 -> DATA2 -> IDLE, where STATUS is skipped under REQ-018 and DATA2 is skipped for type 3; each state hands one byte to the serializer and waits for it to finish.
REQ-021 SHALL frame each byte as 8N1: start bit 0, eight data bits LSB first, stop bit 1, each bit BAUD_DIV cycles, 10*BAUD_DIV cycles per byte.
REQ-022 SHALL drive the start bit of the first byte exactly 2 cycles after the accept edge.
REQ-023 SHALL send consecutive bytes of one event back-to-back, with the next start bit directly after the previous stop bit.
REQ-024 SHALL return ev_ready high on the cycle after the last stop bit ends, so a new event's start bit follows with a 2-cycle idle-high gap.
REQ-025 SHALL drive busy = ~ev_ready.

Reset
REQ-026 SHALL, on reset_reg high, on the next edge set: state IDLE, midi_txd=1, ev_ready=1, busy=0, baud and bit counters 0, and last_status=0x00 (invalid, so the next status byte is always sent).
REQ-027 SHALL abort any event in flight when reset arrives mid-byte, truncating the frame and driving midi_txd high; no partial byte is resumed.
REQ-028 SHALL not accept an event on a cycle where reset_reg is high.

Structure
REQ-029 SHALL place the ev_type encoding, the status nibble constants and the FSM state enum in shared package synth_pkg.
REQ-030 SHALL implement serialization in sub-module midi_uart_tx (ports: load, byte, ready, txd; parameter BAUD_DIV); midi_event_tx owns the event FSM and running status.

Verification (BAUD_DIV=4)
REQ-031 SHALL cover: after reset, midi_ch=2, note on key 0x3C vel 0x64 -> bytes 0x92 0x3C 0x64, 120 cycles, first start bit 2 cycles after accept.
REQ-032 SHALL cover: the same note on followed by note on 0x40/0x7F -> second event sends only 0x40 0x7F (80 cycles); with RUNNING_STATUS=0 it sends 0x92 0x40 0x7F.
REQ-033 SHALL cover: program change 5 on channel 0 -> 0xC0 0x05 only; a following controller 7 = 0x50 -> 0xB0 0x07 0x50.
REQ-034 SHALL cover: pitch bend LSB 0x00 MSB 0x40 on channel 15 -> 0xEF 0x00 0x40; ev_type=6 -> no txd activity and ev_ready low for one cycle.
REQ-035 SHALL cover: reset asserted during bit 3 of the data1 byte -> midi_txd high next cycle, ev_ready=1; the next identical event resends its status byte.
REQ-036 SHALL cover: ev_valid held high with random input changes while busy -> exactly one accept per event and bytes match the latched values.
